rs_syndrome_calc: RTL and testbench
===================================

Name: rs_syndrome_calc

Overview:
Syndrome computation stage at the front of the RS(31,k) decoder over GF(2^5), primitive polynomial x^5+x^2+1. It accepts one received 5-bit symbol per valid cycle and evaluates r(alpha^j) for j=1..NSYN using Horner accumulation. It presents all syndromes in parallel, with a nonzero flag, to the downstream key-equation solver.

Parameters:
N, 31, symbols per codeword (counter wraps at N-1)
NSYN, 6, number of syndromes (2t); first consecutive root fixed at alpha^1

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_symbol is valid this cycle
in_symbol  input  5  received symbol, bit 4 = MSB (x^4 coefficient); highest-degree symbol r_(N-1) first
out_valid  output  1  one-cycle pulse: out_syndromes/out_error valid for a completed block
out_syndromes  output  5*NSYN  S_j at bits [5j-1:5j-5], j=1..NSYN
out_error  output  1  OR of all syndrome bits of the completed block
busy  output  1  high while a block is partially received (count != 0)

Behaviour:
- One clock; reset is synchronous and active-high (ports clock and reset).
- Reset: count=0, all accumulators=0, out_valid=0, out_syndromes=0, out_error=0, busy=0.
- Symbol counter count in 0..N-1, advances only on in_valid; wraps N-1 -> 0.
- Accumulate on in_valid:
  - count==0: S_j <= in_symbol for all j (load; prior contents discarded).
  - else: S_j <= S_j*alpha^j XOR in_symbol.
  - Constant multipliers: fixed XOR networks per j, reduction x^5 = x^2+1; no general multiplier.
- Completion: the in_valid cycle with count==N-1 also computes final S_j.
  - Next cycle: out_valid=1, out_syndromes = final S_j, out_error = |final S.
  - Latency: 1 cycle from last symbol accepted to out_valid.
- Output registers hold last block's values until the next completion or reset; out_valid high exactly one cycle per block.
- in_valid low: counter and accumulators hold; gaps of any length are allowed anywhere in the block.
- Back-to-back blocks: the symbol after N-1 (count wrapped to 0) starts the next block in the same cycle out_valid pulses for the previous one; no dead cycle required.
- busy = (count != 0).
- Reset mid-block: partial block discarded, outputs cleared; the next in_valid symbol is treated as r_(N-1) of a new block.
- Reset asserted in the out_valid cycle: out_valid forced 0.
- No backpressure: downstream must capture on the out_valid pulse.

Test Plan:
- All-zero codeword: 31 consecutive symbols 0 -> out_valid 1 cycle after the 31st symbol; out_syndromes=0; out_error=0.
- Single error at r_0: 30 zeros then 1 -> every S_j=5'b00001; out_error=1.
- Single error at r_1: 29 zeros, then 1, then 0 -> S1=00010, S2=00100, S3=01000, S4=10000, S5=00101, S6=01010.
- Single error at r_30: first symbol 1, then 30 zeros -> S1=10010 (alpha^30), S2=01001 (alpha^29).
- Stalls and streaming:
  - Repeat the r_1 case with random in_valid gaps -> identical syndromes, one out_valid pulse.
  - Two blocks back-to-back (r_0 error, then all-zero) -> pulses 31 cycles apart: first all 00001 with out_error=1, second all 0 with out_error=0.
- Reset after 15 symbols, then a full all-zero block -> no out_valid for the partial block; busy=0 after reset; next pulse shows syndromes 0.

Source files
------------

// File: rtl/rs_syndrome_calc_if.sv
// Symbol-in / syndrome-out bundle between the received-symbol source, the syndrome
// stage and the key-equation solver.
interface rs_syndrome_calc_if #(
    parameter int unsigned NSYN = 6
);
    logic                  in_valid;
    logic [4:0]            in_symbol;
    logic                  out_valid;
    logic [5*NSYN-1:0]     out_syndromes;
    logic                  out_error;
    logic                  busy;

    // Symbol source side
    modport master (
        output in_valid,
        output in_symbol,
        input  out_valid,
        input  out_syndromes,
        input  out_error,
        input  busy
    );

    // Syndrome calculator side
    modport slave (
        input  in_valid,
        input  in_symbol,
        output out_valid,
        output out_syndromes,
        output out_error,
        output busy
    );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(31,k) syndrome stage over GF(2^5), p(x) = x^5 + x^2 + 1.
// Horner-evaluates r(alpha^j), j = 1..NSYN, one symbol per valid cycle, highest degree first.
module rs_syndrome_calc #(
    parameter int unsigned N    = 31,
    parameter int unsigned NSYN = 6
) (
    input  logic              clock,
    input  logic              reset,
    rs_syndrome_calc_if.slave bus
);
    localparam int unsigned     CW      = $clog2(N);
    localparam logic [CW-1:0]   LastCnt = CW'(N - 1);

    logic [CW-1:0]      count_q, count_d;
    logic [4:0]         acc_q [NSYN];
    logic [4:0]         acc_d [NSYN];
    logic [4:0]         acc_mul [NSYN];
    logic [5*NSYN-1:0]  acc_flat;
    logic [5*NSYN-1:0]  syn_q, syn_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               last_sym;

    // Multiply by alpha: shift, fold x^5 back as x^2 + 1.
    function automatic logic [4:0] mul_alpha(input logic [4:0] a);
        return {a[3:0], 1'b0} ^ (a[4] ? 5'b00101 : 5'b00000);
    endfunction

    // Multiply by alpha^p; p is an elaboration constant, so this flattens to an XOR network.
    function automatic logic [4:0] mul_alpha_pow(input logic [4:0] a, input int unsigned p);
        logic [4:0] r;
        r = a;
        for (int unsigned k = 0; k < p; k++) begin
            r = mul_alpha(r);
        end
        return r;
    endfunction

    for (genvar g = 0; g < NSYN; g++) begin : g_mul
        assign acc_mul[g] = mul_alpha_pow(acc_q[g], g + 1);
    end

    assign last_sym = bus.in_valid && (count_q == LastCnt);

    // Next-state for the symbol counter and the Horner accumulators.
    always_comb begin
        count_d = count_q;
        for (int j = 0; j < NSYN; j++) begin
            acc_d[j] = acc_q[j];
        end
        if (bus.in_valid) begin
            count_d = last_sym ? '0 : count_q + 1'b1;
            for (int j = 0; j < NSYN; j++) begin
                // First symbol of a block overwrites whatever the previous block left.
                acc_d[j] = (count_q == '0) ? bus.in_symbol : (acc_mul[j] ^ bus.in_symbol);
            end
        end
    end

    // Next-state for the output holding registers; they only move on block completion.
    always_comb begin
        acc_flat = '0;
        for (int j = 0; j < NSYN; j++) begin
            acc_flat[5*j +: 5] = acc_d[j];
        end
        valid_d = last_sym;
        syn_d   = last_sym ? acc_flat : syn_q;
        err_d   = last_sym ? (|acc_flat) : err_q;
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            for (int j = 0; j < NSYN; j++) begin
                acc_q[j] <= '0;
            end
            syn_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            for (int j = 0; j < NSYN; j++) begin
                acc_q[j] <= acc_d[j];
            end
            syn_q   <= syn_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_syndromes = syn_q;
    assign bus.out_error     = err_q;
    assign bus.busy          = (count_q != '0);
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: directed codewords plus random blocks with gaps, scored
// against a direct polynomial-evaluation model of r(alpha^j).
module tb_rs_syndrome_calc;
    localparam int NS = 31;
    localparam int NJ = 6;

    logic clock;
    logic reset;

    rs_syndrome_calc_if #(.NSYN(NJ)) bus ();

    rs_syndrome_calc #(
        .N    (NS),
        .NSYN (NJ)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // GF(2^5) multiply by shift-and-add.
    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] p;
        logic [5:0] aa;
        p  = '0;
        aa = {1'b0, a};
        for (int k = 0; k < 5; k++) begin
            if (b[k]) p ^= aa[4:0];
            aa = aa << 1;
            if (aa[5]) aa ^= 6'b100101;
        end
        return p;
    endfunction

    function automatic logic [4:0] alpha_pow(input int e);
        logic [4:0] r;
        r = 5'd1;
        for (int k = 0; k < (e % 31); k++) r = gf_mul(r, 5'd2);
        return r;
    endfunction

    // blk[0] is r_30 (first received), blk[30] is r_0.
    function automatic logic [29:0] ref_syn(input logic [4:0] blk[31]);
        logic [29:0] s;
        logic [4:0]  acc;
        s = '0;
        for (int j = 1; j <= NJ; j++) begin
            acc = '0;
            for (int i = 0; i < NS; i++) acc ^= gf_mul(blk[i], alpha_pow(j * (NS - 1 - i)));
            s[5*j-5 +: 5] = acc;
        end
        return s;
    endfunction

    // Scoreboard state
    logic [4:0]  m_blk [31];
    int          m_cnt     = 0;
    int          m_blocks  = 0;
    logic        exp_valid = 1'b0;
    logic [29:0] exp_syn   = '0;
    logic        exp_err   = 1'b0;
    bit          chk_en    = 1'b0;
    int          cyc       = 0;
    int          pulses    = 0;
    logic [29:0] syn_hist [$];
    int          cyc_hist [$];

    // Check outputs of the last posedge, then fold in inputs the next posedge will take.
    always @(negedge clock) begin
        cyc++;
        if (chk_en) begin
            check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check_eq("out_syndromes", 32'(bus.out_syndromes), 32'(exp_syn));
            check_eq("out_error", 32'(bus.out_error), 32'(exp_err));
            check_eq("busy", 32'(bus.busy), 32'(m_cnt != 0));
            if (bus.out_valid === 1'b1) begin
                pulses++;
                syn_hist.push_back(bus.out_syndromes);
                cyc_hist.push_back(cyc);
            end
        end
        exp_valid = 1'b0;
        if (reset) begin
            m_cnt   = 0;
            exp_syn = '0;
            exp_err = 1'b0;
            chk_en  = 1'b1;
        end else if (bus.in_valid) begin
            m_blk[m_cnt] = bus.in_symbol;
            m_cnt++;
            if (m_cnt == NS) begin
                exp_syn   = ref_syn(m_blk);
                exp_err   = |exp_syn;
                exp_valid = 1'b1;
                m_cnt     = 0;
                m_blocks++;
            end
        end
    end

    // Leaves in_valid high on the last symbol so a following call streams with no gap.
    task automatic drive_syms(input logic [4:0] syms[31], input int len, input int gap_max);
        for (int i = 0; i < len; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(posedge clock); #1;
                bus.in_valid = 1'b0;
            end
            @(posedge clock); #1;
            bus.in_valid  = 1'b1;
            bus.in_symbol = syms[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    logic [4:0]  blk [31];
    logic [29:0] s_r1;
    int          p0;

    task automatic clear_blk();
        for (int i = 0; i < NS; i++) blk[i] = 5'd0;
    endtask

    initial begin
        s_r1 = {5'b01010, 5'b00101, 5'b10000, 5'b01000, 5'b00100, 5'b00010};
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_symbol = 5'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // All-zero codeword
        clear_blk();
        drive_syms(blk, NS, 0);
        idle(3);
        check_eq("zero_pulses", 32'(pulses), 32'd1);
        check_eq("zero_syn", 32'(syn_hist[$]), 32'd0);

        // Single error at r_0
        clear_blk();
        blk[30] = 5'd1;
        drive_syms(blk, NS, 0);
        idle(3);
        check_eq("r0_syn", 32'(syn_hist[$]), 32'({6{5'b00001}}));

        // Single error at r_1
        clear_blk();
        blk[29] = 5'd1;
        drive_syms(blk, NS, 0);
        idle(3);
        check_eq("r1_syn", 32'(syn_hist[$]), 32'(s_r1));

        // Single error at r_30
        clear_blk();
        blk[0] = 5'd1;
        drive_syms(blk, NS, 0);
        idle(3);
        check_eq("r30_s1s2", 32'(syn_hist[$][9:0]), 32'(10'b01001_10010));

        // r_1 with random stalls
        p0 = pulses;
        clear_blk();
        blk[29] = 5'd1;
        drive_syms(blk, NS, 3);
        idle(3);
        check_eq("r1_gap_syn", 32'(syn_hist[$]), 32'(s_r1));
        check_eq("r1_gap_pulses", 32'(pulses - p0), 32'd1);

        // Back-to-back: r_0 error block then all-zero block, no dead cycle
        clear_blk();
        blk[30] = 5'd1;
        drive_syms(blk, NS, 0);
        clear_blk();
        drive_syms(blk, NS, 0);
        idle(3);
        check_eq("b2b_first", 32'(syn_hist[$-1]), 32'({6{5'b00001}}));
        check_eq("b2b_second", 32'(syn_hist[$]), 32'd0);
        check_eq("b2b_spacing", 32'(cyc_hist[$] - cyc_hist[$-1]), 32'd31);

        // Reset after 15 symbols, then a clean all-zero block
        p0 = pulses;
        clear_blk();
        blk[3] = 5'd7;
        drive_syms(blk, 15, 0);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_out_error", 32'(bus.out_error), 32'd0);
        check_eq("rst_no_pulse", 32'(pulses - p0), 32'd0);
        clear_blk();
        drive_syms(blk, NS, 0);
        idle(3);
        check_eq("rst_next_pulses", 32'(pulses - p0), 32'd1);
        check_eq("rst_next_syn", 32'(syn_hist[$]), 32'd0);

        // Random blocks with random gaps, sometimes streamed back-to-back
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < NS; i++) blk[i] = 5'($urandom_range(31, 0));
            if ($urandom_range(3, 0) == 0) blk[$urandom_range(30, 0)] ^= 5'd1;
            drive_syms(blk, NS, int'($urandom_range(2, 0)));
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(4, 1)));
        end
        idle(4);
        check_eq("total_pulses", 32'(pulses), 32'(m_blocks));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
